multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 run  in  1  1 = keep issuing instructions; 0 = stop after the current instruction.
REQ-005 instruction  in  32  instruction-register contents; stable from DECODE to end of instruction.
REQ-006 alu_zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  in  1  memory completion handshake.
REQ-008 alu_op  out  2  ALUOp to the ALU control decoder.
REQ-009 alu_src  out  1  0 = register operand, 1 = immediate.
REQ-010 reg2loc  out  1  1 = second read register from Rt (instruction[4:0]).
REQ-011 ir_write, pc_write, pc_src, mem_read, mem_write, reg_write, mem_to_reg  out  1 each  datapath strobes; pc_src: 0 = PC+4, 1 = branch target.
REQ-012 instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-013 halted  out  1  high in HALT.
REQ-014 state  out  4  encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM_RD=4, MEM_WR=5, WB=6, BRANCH=7, HALT=8.

Function
REQ-015 Opcode classes on instruction[31:21]: R = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11101010000; I = 1001000100x, 1101000100x, 1001001000x, 1011001000x, 1101001000x; LDUR 11111000010; STUR 11111000000; CB = 1011010xxxx; MOVZ 110100101xx; B 000101xxxxx; anything else is illegal.
REQ-016 IDLE: all strobes 0; go to FETCH when run=1.
REQ-017 FETCH: mem_read=1; on the cycle mem_ready=1, ir_write=1, pc_write=1, pc_src=0, and go to DECODE; otherwise hold FETCH.
REQ-018 DECODE: one cycle; R/I/LDUR/STUR/MOVZ go to EXEC, CB/B go to BRANCH, illegal goes to HALT.
REQ-019 EXEC: one cycle; alu_op=10 for R/I, 00 for LDUR/STUR, 01 for MOVZ; alu_src=1 for I/LDUR/STUR/MOVZ; reg2loc=1 for STUR; next state MEM_RD (LDUR), MEM_WR (STUR), else WB.
REQ-020 MEM_RD: mem_read=1 and alu_op=00 held until mem_ready=1, then go to WB.
REQ-021 MEM_WR: mem_write=1 and reg2loc=1 held until mem_ready=1; that cycle is the last of the instruction.
REQ-022 WB: reg_write=1; mem_to_reg=1 only for LDUR.
REQ-023 BRANCH: alu_op=01 and reg2loc=1. CBZ is taken when alu_zero=1 and CBNZ (instruction[24]=1) when alu_zero=0; B is always taken. A taken branch drives pc_write=1, pc_src=1.
REQ-024 instr_done=1 on the last cycle of WB, BRANCH and MEM_WR; next state is FETCH if run=1, else IDLE.
REQ-025 When run falls mid-instruction, the current instruction SHALL complete.
REQ-026 HALT: halted=1 with all strobes 0; the block stays in HALT until reset.
REQ-027 mem_ready SHALL be ignored outside FETCH, MEM_RD and MEM_WR.
REQ-028 Every unlisted output in every state SHALL be 0, and alu_op SHALL be 00.
REQ-029 Outputs SHALL be a function of the state register and instruction only (Moore), with no combinational path from mem_ready or alu_zero except pc_write in BRANCH and the strobes qualified by mem_ready.

Reset
REQ-030 While rst_n=0, state SHALL be IDLE immediately, regardless of clk.
REQ-031 While rst_n=0, all outputs SHALL be 0.
REQ-032 Reset asserted mid-instruction SHALL abandon the instruction with no further strobes.
REQ-033 Reset SHALL be the only exit from HALT.

Configuration
REQ-034 With MULTICYCLE_MEM_WAIT_EN defined, FETCH, MEM_RD and MEM_WR SHALL wait on mem_ready as specified.
REQ-035 Without MULTICYCLE_MEM_WAIT_EN, the mem_ready port SHALL remain but be ignored, and each of those states SHALL last exactly one cycle (mem_ready treated as 1).

Verification
REQ-036 Reset, run=1, mem_ready=1, instruction=0x8B020020 (ADD) -> states 1,2,3,6; alu_op=10 in EXEC; reg_write=1 and instr_done=1 in WB; re-enter FETCH.
REQ-037 With MEM_WAIT_EN, LDUR 0xF8400020 and mem_ready low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles with mem_read=1; then WB with reg_write=1, mem_to_reg=1.
REQ-038 CBZ 0xB4000040 -> with alu_zero=1: BRANCH, pc_write=1, pc_src=1; repeated with alu_zero=0: pc_write=0, instr_done=1.
REQ-039 instruction=0x00000000 -> DECODE then HALT, halted=1 for 20 cycles despite run=1; rst_n pulse -> IDLE, halted=0.
REQ-040 rst_n low while in MEM_WR (STUR 0xF8000020, mem_ready=0) -> state=0 and mem_write=0 before the next clk edge.
REQ-041 Without MEM_WAIT_EN, STUR with mem_ready=0 -> MEM_WR lasts one cycle with mem_write=1 and instr_done=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Define MULTICYCLE_MEM_WAIT_EN to make FETCH, MEM_RD and MEM_WR wait on mem_ready.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] instruction,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        reg2loc,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic        halted,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB     = 4'd6,
        S_BRANCH = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        C_ILLEGAL,
        C_R,
        C_I,
        C_LDUR,
        C_STUR,
        C_CB,
        C_MOVZ,
        C_B
    } class_e;

    state_e state_q;
    state_e state_d;
    class_e op_class;
    logic   mem_rdy;
    logic   branch_taken;
    logic   unused_instr;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    // Memory is assumed single-cycle; the port is kept for pin compatibility.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_rdy          = 1'b1;
`endif

    assign unused_instr = ^instruction[20:0];

    always_comb begin
        op_class = C_ILLEGAL;
        casez (instruction[31:21])
            11'b10001011000, 11'b11001011000, 11'b10001010000,
            11'b10101010000, 11'b11101010000:                   op_class = C_R;
            11'b1001000100?, 11'b1101000100?, 11'b1001001000?,
            11'b1011001000?, 11'b1101001000?:                   op_class = C_I;
            11'b11111000010:                                    op_class = C_LDUR;
            11'b11111000000:                                    op_class = C_STUR;
            11'b1011010????:                                    op_class = C_CB;
            11'b110100101??:                                    op_class = C_MOVZ;
            11'b000101?????:                                    op_class = C_B;
            default:                                            op_class = C_ILLEGAL;
        endcase
    end

    // Bit 24 distinguishes CBNZ from CBZ.
    assign branch_taken = (op_class == C_B) ||
                          ((op_class == C_CB) && (instruction[24] ? !alu_zero : alu_zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        reg2loc    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_rdy) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_class)
                    C_R, C_I, C_LDUR, C_STUR, C_MOVZ: state_d = S_EXEC;
                    C_CB, C_B:                        state_d = S_BRANCH;
                    default:                          state_d = S_HALT;
                endcase
            end
            S_EXEC: begin
                case (op_class)
                    C_R:          alu_op = 2'b10;
                    C_I: begin
                        alu_op  = 2'b10;
                        alu_src = 1'b1;
                    end
                    C_MOVZ: begin
                        alu_op  = 2'b01;
                        alu_src = 1'b1;
                    end
                    C_LDUR:       alu_src = 1'b1;
                    C_STUR: begin
                        alu_src = 1'b1;
                        reg2loc = 1'b1;
                    end
                    default:      alu_op = 2'b00;
                endcase
                if (op_class == C_LDUR)      state_d = S_MEM_RD;
                else if (op_class == C_STUR) state_d = S_MEM_WR;
                else                         state_d = S_WB;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (mem_rdy) state_d = S_WB;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                reg2loc   = 1'b1;
                if (mem_rdy) begin
                    instr_done = 1'b1;
                    state_d    = run ? S_FETCH : S_IDLE;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_class == C_LDUR);
                instr_done = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_BRANCH: begin
                alu_op     = 2'b01;
                reg2loc    = 1'b1;
                pc_write   = branch_taken;
                pc_src     = branch_taken;
                instr_done = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule
